ps2_digit_decoder: RTL and testbench
====================================

Name: ps2_digit_decoder

Overview:
- Front-end stage of the keyboard-interfacing path, directly upstream of the LCD character driver.
- Receives PS/2 (scan code set 2) frames from the keyboard pins and validates framing and parity.
- Tracks make/break/extended prefixes and converts digit-key make codes to a held 4-bit value 0–9.
- That held value drives the LCD driver's `number` input.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before the ps2_clk level is accepted (glitch filter).
- TIMEOUT_CYCLES, 100000: system clocks without a filtered falling edge mid-frame before the frame is aborted (2 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- ps2_clk  input  1  raw PS/2 clock pin (asynchronous)
- ps2_data  input  1  raw PS/2 data pin (asynchronous)
- number  output  4  last accepted digit, 0–9, held until replaced
- number_valid  output  1  one-cycle pulse when `number` is updated
- scan_code  output  8  last correctly framed byte
- frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error

Behaviour:
- Reset (rst_n low at a clk edge):
  - number=0, number_valid=0, scan_code=8'h00, frame_err=0.
  - FSM=IDLE, break and extended flags cleared, filter and timeout counters cleared.
  - Reset mid-frame discards the partial byte.
- Input conditioning:
  - Both pins pass through a 2-flop synchronizer.
  - ps2_clk then passes the FILTER_LEN glitch filter.
  - A falling edge is a 1→0 change of the filtered clock.
  - ps2_data is sampled from the synchronizer output in the same cycle the falling edge is detected.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0, go to DATA and clear bit_cnt. With data=1 (bad start), stay in IDLE; no error is raised.
  - DATA: shift data into shreg[7] (right shift) on each edge. After the 8th bit (bit_cnt=7), go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: the stop bit must be 1 and ^{shreg,parity} must be 1.
    - Success: byte accepted.
    - Failure: frame_err pulses.
    - Either way, return to IDLE.
- Timeout:
  - The timeout counter resets on every falling edge and counts only outside IDLE.
  - On reaching TIMEOUT_CYCLES-1: frame_err pulses, FSM returns to IDLE, and the partial byte and flags are untouched.
- Byte handling is registered; all effects appear the cycle after the STOP-state edge.
  - scan_code is updated for every accepted byte, including prefix bytes.
  - 8'hF0: set break flag.
  - 8'hE0: set extended flag.
  - Any other byte:
    - If break or extended is set: clear both flags; number is unchanged (key release or extended key).
    - Otherwise, if the byte is in the digit map: update number and pulse number_valid.
    - Otherwise: no update.
  - A frame with an error leaves the flags unchanged.
- Digit map (main row): 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
- Typematic repeats of the same make code pulse number_valid each time.
- Simultaneous events: a falling edge in the same cycle as a timeout terminal count is treated as an edge; the timeout is suppressed.

Optional Feature:
- Macro NUMPAD_MAP_EN.
  - Defined: the non-extended keypad codes are also mapped: 70→0, 69→1, 72→2, 7A→3, 6B→4, 73→5, 74→6, 6C→7, 75→8, 7D→9.
  - Undefined: these codes are accepted into scan_code only; number is unchanged and there is no number_valid pulse.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum.
  - Constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0.
  - A digit-lookup function (byte → {hit, 4-bit value}), including the keypad entries under NUMPAD_MAP_EN.
- One sub-module, ps2_clk_filter: synchronizer, glitch filter and falling-edge pulse.
- The top level holds the FSM, shift register, timeout and prefix logic.

Test Plan:
- Send frame 8'h26 (odd parity bit=0) → scan_code=26, number=3, one-cycle number_valid pulse, no frame_err.
- Send 16, then F0, 16 → number=1 with a single number_valid pulse. After F0 16, number stays 1, scan_code=16, and there is no further number_valid.
- Send 45 with parity flipped → frame_err pulses once, number unchanged, FSM back in IDLE. A following valid 2E yields number=5.
- Stop ps2_clk after 4 data bits for more than TIMEOUT_CYCLES → frame_err pulses once at the terminal count. A following valid 46 yields number=9.
- Inject 3-clk-wide ps2_clk glitches (with FILTER_LEN=8) during a 3D frame; also send E0 70 → 3D yields number=7. E0 70 leaves number=7 in both builds. Separately, 70 alone yields number=0 only with NUMPAD_MAP_EN.
- Assert rst_n low for one cycle mid-frame (after 5 bits) → all outputs return to reset values. The next full frame of 1E yields number=2.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, constants and digit lookup for the PS/2 digit decoder
//
// Purpose: frame FSM state encoding, scan code set 2 prefix bytes, and the
//          make-code to digit lookup used by ps2_digit_decoder.
// Build option: NUMPAD_MAP_EN adds the non-extended keypad digit codes to the lookup.
// Ports: none (package).

package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Returns {hit, value}; hit=0 means the byte is not a digit make code.
  function automatic logic [4:0] digit_lookup(input logic [7:0] code);
    logic [4:0] r;
    r = 5'b0_0000;
    case (code)
      8'h45: r = {1'b1, 4'd0};
      8'h16: r = {1'b1, 4'd1};
      8'h1E: r = {1'b1, 4'd2};
      8'h26: r = {1'b1, 4'd3};
      8'h25: r = {1'b1, 4'd4};
      8'h2E: r = {1'b1, 4'd5};
      8'h36: r = {1'b1, 4'd6};
      8'h3D: r = {1'b1, 4'd7};
      8'h3E: r = {1'b1, 4'd8};
      8'h46: r = {1'b1, 4'd9};
`ifdef NUMPAD_MAP_EN
      8'h70: r = {1'b1, 4'd0};
      8'h69: r = {1'b1, 4'd1};
      8'h72: r = {1'b1, 4'd2};
      8'h7A: r = {1'b1, 4'd3};
      8'h6B: r = {1'b1, 4'd4};
      8'h73: r = {1'b1, 4'd5};
      8'h74: r = {1'b1, 4'd6};
      8'h6C: r = {1'b1, 4'd7};
      8'h75: r = {1'b1, 4'd8};
      8'h7D: r = {1'b1, 4'd9};
`endif
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - PS/2 pin synchronizer, clock glitch filter and falling-edge pulse
//
// Purpose: brings the asynchronous PS/2 pins into the clk domain, accepts a new
//          ps2_clk level only after FILTER_LEN consecutive identical samples,
//          and pulses fall_o for one cycle on a 1->0 change of the filtered clock.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   ps2_clk_i  in   raw PS/2 clock pin
//   ps2_data_i in   raw PS/2 data pin
//   fall_o     out  one-cycle pulse on a filtered falling edge
//   data_o     out  synchronized data, valid to sample while fall_o is high

module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q, filt_d;
  logic          filt_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with the filtered level;
  // any agreeing sample restarts the run.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pins idle high, so reset everything to the released level to avoid a
  // spurious edge after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q       <= cnt_d;
    end
  end

  assign fall_o = filt_prev_q & ~filt_q;
  assign data_o = data_sync_q[1];

endmodule

// File: rtl/ps2_digit_decoder.sv
// rtl/ps2_digit_decoder.sv - PS/2 frame receiver and digit-key decoder (top)
//
// Purpose: receives scan code set 2 frames, checks start/parity/stop framing
//          with a mid-frame timeout, tracks break/extended prefixes and holds
//          the last digit make code as a 4-bit value for the LCD driver.
// Build option: NUMPAD_MAP_EN also maps the non-extended keypad digits.
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   ps2_clk      in   raw PS/2 clock pin (asynchronous)
//   ps2_data     in   raw PS/2 data pin (asynchronous)
//   number       out  last accepted digit 0-9, held until replaced
//   number_valid out  one-cycle pulse when number is updated
//   scan_code    out  last correctly framed byte
//   frame_err    out  one-cycle pulse on parity, stop-bit or timeout error

module ps2_digit_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] number,
  output logic       number_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic fall;
  logic data_s;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .fall_o    (fall),
    .data_o    (data_s)
  );

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [3:0]    number_q, number_d;
  logic          number_valid_q, number_valid_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          frame_err_q, frame_err_d;
  logic [4:0]    lookup;

  assign lookup = digit_lookup(shreg_q);

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    parity_d       = parity_q;
    tmo_d          = tmo_q;
    brk_d          = brk_q;
    ext_d          = ext_q;
    number_d       = number_q;
    number_valid_d = 1'b0;
    scan_code_d    = scan_code_q;
    frame_err_d    = 1'b0;

    // An edge always wins over a coincident timeout terminal count.
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          // A high start bit is silently ignored.
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shreg_d   = {data_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_s && (^{shreg_q, parity_q})) begin
            scan_code_d = shreg_q;
            if (shreg_q == PS2_BREAK) begin
              brk_d = 1'b1;
            end else if (shreg_q == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (brk_q || ext_q) begin
              // Key release or extended key: consume the prefixes only.
              brk_d = 1'b0;
              ext_d = 1'b0;
            end else if (lookup[4]) begin
              number_d       = lookup[3:0];
              number_valid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // Abort leaves the partial byte and prefix flags as they are.
      if (tmo_q == TMO_LAST) begin
        frame_err_d = 1'b1;
        state_d     = ST_IDLE;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= 3'd0;
      shreg_q        <= 8'h00;
      parity_q       <= 1'b0;
      tmo_q          <= '0;
      brk_q          <= 1'b0;
      ext_q          <= 1'b0;
      number_q       <= 4'd0;
      number_valid_q <= 1'b0;
      scan_code_q    <= 8'h00;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      parity_q       <= parity_d;
      tmo_q          <= tmo_d;
      brk_q          <= brk_d;
      ext_q          <= ext_d;
      number_q       <= number_d;
      number_valid_q <= number_valid_d;
      scan_code_q    <= scan_code_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign number       = number_q;
  assign number_valid = number_valid_q;
  assign scan_code    = scan_code_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_digit_decoder.sv
// tb/tb_ps2_digit_decoder.sv - directed self-checking bench for ps2_digit_decoder

module tb_ps2_digit_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 300;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] number;
  logic       number_valid;
  logic [7:0] scan_code;
  logic       frame_err;

  int vectors;
  int miscompares;
  int nv_cnt;
  int fe_cnt;

  ps2_digit_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .number      (number),
    .number_valid(number_valid),
    .scan_code   (scan_code),
    .frame_err   (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters; each count is one cycle of the output being high.
  initial begin
    nv_cnt = 0;
    fe_cnt = 0;
    forever begin
      @(negedge clk);
      if (number_valid === 1'b1) nv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of {stop, parity, data[7:0], start}, 50 clk per bit.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
    logic [10:0] fr;
    logic        par;
    par = ~(^b) ^ bad_par;
    fr  = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch) begin
        wait_cyc(4);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b1;
        wait_cyc(3);
        ps2_clk = 1'b0;
        wait_cyc(12);
      end else begin
        wait_cyc(12);
        ps2_clk = 1'b0;
        wait_cyc(25);
      end
      ps2_clk = 1'b1;
      wait_cyc(13);
    end
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b, input bit bad_par, input bit glitch,
                             input logic [3:0] exp_num, input logic [7:0] exp_scan,
                             input int exp_nv, input int exp_fe);
    int nv0;
    int fe0;
    nv0 = nv_cnt;
    fe0 = fe_cnt;
    send_bits(b, bad_par, glitch, 11);
    wait_cyc(20);
    check({tag, ".number"}, 32'(number), 32'(exp_num));
    check({tag, ".scan_code"}, 32'(scan_code), 32'(exp_scan));
    check({tag, ".nv_pulses"}, 32'(nv_cnt - nv0), 32'(exp_nv));
    check({tag, ".fe_pulses"}, 32'(fe_cnt - fe0), 32'(exp_fe));
  endtask

  initial begin
    int nv0;
    int fe0;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(2);

    check("rst.number", 32'(number), 32'h0);
    check("rst.number_valid", 32'(number_valid), 32'h0);
    check("rst.scan_code", 32'(scan_code), 32'h00);
    check("rst.frame_err", 32'(frame_err), 32'h0);

    frame_check("k26", 8'h26, 1'b0, 1'b0, 4'd3, 8'h26, 1, 0);
    frame_check("k26_rep", 8'h26, 1'b0, 1'b0, 4'd3, 8'h26, 1, 0);
    frame_check("k16", 8'h16, 1'b0, 1'b0, 4'd1, 8'h16, 1, 0);
    frame_check("brkF0", 8'hF0, 1'b0, 1'b0, 4'd1, 8'hF0, 0, 0);
    frame_check("brk16", 8'h16, 1'b0, 1'b0, 4'd1, 8'h16, 0, 0);
    frame_check("bad45", 8'h45, 1'b1, 1'b0, 4'd1, 8'h16, 0, 1);
    frame_check("k2E", 8'h2E, 1'b0, 1'b0, 4'd5, 8'h2E, 1, 0);

    // Clock stops after start + 4 data bits.
    nv0 = nv_cnt;
    fe0 = fe_cnt;
    send_bits(8'hA5, 1'b0, 1'b0, 5);
    wait_cyc(TIMEOUT_CYCLES + 100);
    check("tmo.fe_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("tmo.nv_pulses", 32'(nv_cnt - nv0), 32'd0);
    check("tmo.number", 32'(number), 32'd5);
    check("tmo.scan_code", 32'(scan_code), 32'h2E);
    frame_check("k46", 8'h46, 1'b0, 1'b0, 4'd9, 8'h46, 1, 0);

    frame_check("glitch3D", 8'h3D, 1'b0, 1'b1, 4'd7, 8'h3D, 1, 0);
    frame_check("extE0", 8'hE0, 1'b0, 1'b0, 4'd7, 8'hE0, 0, 0);
    frame_check("ext70", 8'h70, 1'b0, 1'b0, 4'd7, 8'h70, 0, 0);
`ifdef NUMPAD_MAP_EN
    frame_check("kp70", 8'h70, 1'b0, 1'b0, 4'd0, 8'h70, 1, 0);
`else
    frame_check("kp70", 8'h70, 1'b0, 1'b0, 4'd7, 8'h70, 0, 0);
`endif

    // One-cycle reset after start + 5 data bits.
    send_bits(8'h5A, 1'b0, 1'b0, 6);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    check("mrst.number", 32'(number), 32'h0);
    check("mrst.number_valid", 32'(number_valid), 32'h0);
    check("mrst.scan_code", 32'(scan_code), 32'h00);
    check("mrst.frame_err", 32'(frame_err), 32'h0);
    wait_cyc(5);
    frame_check("k1E", 8'h1E, 1'b0, 1'b0, 4'd2, 8'h1E, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
